countdown_ctrl: RTL and testbench

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

---
 rtl/countdown_pkg.sv | 13 +
 rtl/bcd_down4.sv | 47 ++++
 rtl/countdown_ctrl.sv | 159 +++++++++++++++
 tb/tb_countdown_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer controller.
package countdown_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  typedef logic [3:0] bcd_t;

  // Out-of-range BCD digits from the preset switches read as 9.
  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_down4.sv
// Four-digit BCD down-counter with synchronous load and saturation at 0000.
module bcd_down4
  import countdown_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  bcd_t din [3:0],
  output bcd_t q [3:0],
  output logic zero
);

  bcd_t nxt [3:0];
  logic borrow;

  always_comb begin
    zero = (q[3] == 4'd0) && (q[2] == 4'd0) && (q[1] == 4'd0) && (q[0] == 4'd0);
  end

  // Ripple borrow: a zero digit becomes 9 and passes the borrow upward.
  always_comb begin
    nxt    = q;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (q[i] == 4'd0) begin
          nxt[i] = 4'd9;
        end else begin
          nxt[i] = q[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '{default: 4'd0};
    end else if (load) begin
      q <= din;
    end else if (en && !zero) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Pushbutton countdown timer: BCD preset, start/pause/clear, timed alarm.
//
// state | meaning
// IDLE  | counter follows the clamped preset, prescaler parked at 0
// RUN   | prescaler running, counter decrements once per tick
// PAUSE | counter and prescaler frozen
// DONE  | counter at 0000, alarm held for ALARM_TICKS ticks
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int ALARM_TICKS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start_n,
  input  logic btn_clear_n,
  input  bcd_t preset [3:0],
  output bcd_t digit  [5:0],
  output logic running,
  output logic alarm,
  output logic done_pulse
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(ALARM_TICKS + 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic [AW-1:0] alarm_cnt;
  logic [2:0]    start_sync;
  logic [2:0]    clear_sync;
  logic          start_press;
  logic          clear_press;
  logic          tick;
  logic          preset_zero;
  logic          last_one;
  logic          cnt_load;
  logic          cnt_en;
  logic          cnt_zero;
  bcd_t          preset_clamped [3:0];
  bcd_t          cnt_q [3:0];

  // [0],[1] are the two synchronizer flops, [2] holds the previous synced level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_sync <= 3'b111;
      clear_sync <= 3'b111;
    end else begin
      start_sync <= {start_sync[1:0], btn_start_n};
      clear_sync <= {clear_sync[1:0], btn_clear_n};
    end
  end

  always_comb begin
    start_press = start_sync[2] & ~start_sync[1];
    clear_press = clear_sync[2] & ~clear_sync[1];
    for (int i = 0; i < 4; i++) begin
      preset_clamped[i] = bcd_clamp(preset[i]);
    end
    preset_zero = (preset[3] == 4'd0) && (preset[2] == 4'd0) &&
                  (preset[1] == 4'd0) && (preset[0] == 4'd0);
    last_one    = (cnt_q[3] == 4'd0) && (cnt_q[2] == 4'd0) &&
                  (cnt_q[1] == 4'd0) && (cnt_q[0] == 4'd1);
    tick        = ((state == RUN) || (state == DONE)) && (presc == PW'(TICK_DIV - 1));
    presc_next  = tick ? '0 : presc + PW'(1);
    cnt_load    = (state == IDLE);
    cnt_en      = (state == RUN) && tick && !cnt_zero && !clear_press;
  end

  bcd_down4 u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .din  (preset_clamped),
    .q    (cnt_q),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      presc      <= '0;
      alarm      <= 1'b0;
      alarm_cnt  <= '0;
      running    <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (clear_press) begin
        state     <= IDLE;
        presc     <= '0;
        alarm     <= 1'b0;
        alarm_cnt <= '0;
        running   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            presc <= '0;
            if (start_press) begin
              if (preset_zero) begin
                state      <= DONE;
                done_pulse <= 1'b1;
                alarm      <= 1'b1;
                alarm_cnt  <= AW'(ALARM_TICKS);
              end else begin
                state   <= RUN;
                running <= 1'b1;
              end
            end
          end
          RUN: begin
            presc <= presc_next;
            // Reaching zero outranks a coincident pause request.
            if (tick && last_one) begin
              state      <= DONE;
              running    <= 1'b0;
              done_pulse <= 1'b1;
              alarm      <= 1'b1;
              alarm_cnt  <= AW'(ALARM_TICKS);
            end else if (start_press) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
          PAUSE: begin
            if (start_press) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
            presc <= presc_next;
            if (start_press) begin
              state     <= IDLE;
              alarm     <= 1'b0;
              alarm_cnt <= '0;
            end else if (tick && (alarm_cnt != '0)) begin
              alarm_cnt <= alarm_cnt - AW'(1);
              if (alarm_cnt == AW'(1)) alarm <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      digit[i] = cnt_q[i];
    end
    digit[4] = 4'd0;
    digit[5] = 4'd0;
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed and randomized bench for countdown_ctrl against a decimal reference model.
module tb_countdown_ctrl;

  localparam int TD = 4;
  localparam int AT = 2;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bs  = 1'b1;
  logic       bc  = 1'b1;
  logic [3:0] preset [3:0];
  logic [3:0] digit  [5:0];
  logic       running, alarm, done_pulse;

  int checks = 0;
  int errors = 0;
  int dp_cnt = 0;
  int al_cnt = 0;

  // reference model: count kept as a plain decimal integer
  int         m_mode, m_cnt, m_phase, m_alarm_left;
  bit         m_dp;
  logic [2:0] h_s, h_c;

  countdown_ctrl #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_start_n (bs),
    .btn_clear_n (bc),
    .preset      (preset),
    .digit       (digit),
    .running     (running),
    .alarm       (alarm),
    .done_pulse  (done_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dig24();
    return {8'h0, digit[5], digit[4], digit[3], digit[2], digit[1], digit[0]};
  endfunction

  function automatic int preset_val();
    int v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + ((preset[i] > 9) ? 9 : int'(preset[i]));
    return v;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = 0;
    for (int i = 0; i < 4; i++) begin
      r = r | (32'(v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_phase = 0; m_alarm_left = 0; m_dp = 0;
    h_s = 3'b111; h_c = 3'b111;
  endtask

  task automatic enter_done();
    m_mode = M_DONE; m_alarm_left = AT; m_dp = 1;
  endtask

  task automatic model_step();
    bit sp, cp, tk;
    int pv, old;
    if (!rst) begin
      model_reset();
      return;
    end
    sp   = h_s[2] && !h_s[1];
    cp   = h_c[2] && !h_c[1];
    pv   = preset_val();
    old  = m_mode;
    m_dp = 0;
    tk   = (old == M_RUN || old == M_DONE) && (m_phase == TD - 1);
    if (old == M_IDLE) m_cnt = pv;
    if (cp) begin
      m_mode = M_IDLE; m_phase = 0; m_alarm_left = 0;
    end else begin
      case (old)
        M_IDLE: begin
          m_phase = 0;
          if (sp) begin
            if (pv == 0) enter_done();
            else m_mode = M_RUN;
          end
        end
        M_RUN: begin
          m_phase = (m_phase + 1) % TD;
          if (tk && m_cnt > 0) m_cnt = m_cnt - 1;
          if (tk && m_cnt == 0) enter_done();
          else if (sp) m_mode = M_PAUSE;
        end
        M_PAUSE: if (sp) m_mode = M_RUN;
        default: begin
          m_phase = (m_phase + 1) % TD;
          if (sp) begin
            m_mode = M_IDLE; m_alarm_left = 0;
          end else if (tk && m_alarm_left > 0) begin
            m_alarm_left = m_alarm_left - 1;
          end
        end
      endcase
    end
    h_s = {h_s[1:0], bs};
    h_c = {h_c[1:0], bc};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("digit",      dig24(),             to_bcd(m_cnt));
    chk("running",    32'(running),        32'(m_mode == M_RUN));
    chk("alarm",      32'(alarm),          32'(m_mode == M_DONE && m_alarm_left > 0));
    chk("done_pulse", 32'(done_pulse),     32'(m_dp));
    if (done_pulse === 1'b1) dp_cnt++;
    if (alarm === 1'b1) al_cnt++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press(input bit s, input bit c);
    if (s) bs = 1'b0;
    if (c) bc = 1'b0;
    run(4);
    bs = 1'b1;
    bc = 1'b1;
  endtask

  task automatic set_preset(input logic [15:0] p);
    for (int i = 0; i < 4; i++) preset[i] = p[4*i +: 4];
  endtask

  initial begin
    set_preset(16'h0000);
    model_reset();
    #3;
    chk("rst_digit",   dig24(),            32'h0);
    chk("rst_running", 32'(running),       32'h0);
    chk("rst_alarm",   32'(alarm),         32'h0);
    run(2);
    rst = 1'b1;

    // 0012 counts down to 0000, single done pulse, alarm 2 ticks = 8 clk
    set_preset(16'h0012);
    run(1);
    chk("load_0012", dig24(), 32'h0012);
    dp_cnt = 0; al_cnt = 0;
    press(1, 0);
    chk("run_0012", 32'(running), 32'h1);
    run(70);
    chk("dp_once_0012", 32'(dp_cnt), 32'd1);
    chk("alarm_len_0012", 32'(al_cnt), 32'd8);
    chk("final_0012", dig24(), 32'h0);
    press(1, 0);
    run(3);

    // pause/resume at 0099
    set_preset(16'h0100);
    run(1);
    press(1, 0);
    run(3);
    chk("first_dec_0100", dig24(), 32'h0099);
    press(1, 0);
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("pause_frozen", dig24(), 32'h0099);
    end
    press(1, 0);
    run(30);
    press(0, 1);
    run(2);

    // preset zero goes straight to DONE
    set_preset(16'h0000);
    run(1);
    dp_cnt = 0; al_cnt = 0;
    press(1, 0);
    run(16);
    chk("dp_zero_preset", 32'(dp_cnt), 32'd1);
    chk("alarm_len_zero", 32'(al_cnt), 32'd8);
    chk("digit_zero", dig24(), 32'h0);
    press(0, 1);
    run(2);

    // invalid digits clamp to 9
    set_preset(16'hA9F3);
    run(2);
    chk("clamp_9993", dig24(), 32'h9993);
    press(1, 0);
    run(3);
    chk("first_dec_9992", dig24(), 32'h9992);
    press(0, 1);
    run(2);

    // start+clear together at 0005: clear wins
    set_preset(16'h0009);
    run(1);
    press(1, 0);
    for (int i = 0; i < 40 && dig24() !== 32'h0005; i++) cycle();
    chk("reach_0005", dig24(), 32'h0005);
    press(1, 1);
    chk("clr_running", 32'(running), 32'h0);
    chk("clr_digit", dig24(), 32'h0009);
    run(8);
    chk("clr_stays_idle", 32'(running), 32'h0);

    // async reset during alarm
    set_preset(16'h0003);
    run(1);
    press(1, 0);
    for (int i = 0; i < 60 && alarm !== 1'b1; i++) cycle();
    chk("alarm_reached", 32'(alarm), 32'h1);
    run(2);
    dp_cnt = 0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_alarm", 32'(alarm),      32'h0);
    chk("arst_digit", dig24(),         32'h0);
    chk("arst_dp",    32'(done_pulse), 32'h0);
    run(2);
    rst = 1'b1;
    cycle();
    chk("post_rst_preset", dig24(), 32'h0003);
    chk("post_rst_dp", 32'(dp_cnt), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        preset[0] = 4'($urandom_range(0, 15));
        preset[1] = 4'($urandom_range(0, 2));
        preset[2] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        preset[3] = 4'd0;
      end
      if ($urandom_range(0, 9) < 2) bs = ~bs;
      bc = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
